// File: rtl/pwm_drive.sv
// ---------------------------------------------------------------------------
// pwm_drive
//
// Converts the 4-bit duty-cycle step value from the animation ramp generator
// into a glitch-free PWM waveform for an LED pad. A PWM period is STEPS slots
// of SLOT_CLKS clocks each, so it is P = SLOT_CLKS * STEPS clocks long. The
// requested duty is sampled only at period boundaries. This means a change in
// the middle of a period never shortens or splits a pulse that is in
// progress.
//
// Parameters:
//   SLOT_CLKS  clocks per slot (>= 1)
//   STEPS      slots per period, also the full-scale duty value (1..15)
//   INVERT     1 = active-low pad; also inverts the idle/reset level
//
// Ports:
//   clk_i           single clock, rising edge
//   rst_ni          asynchronous active-low reset
//   en_i            run enable, level-sensitive
//   duty_cycle_i    requested on-slots per period (saturates to STEPS)
//   pwm_o           registered PWM output
//   period_done_o   registered one-cycle strobe in the last clock of a period
//   active_duty_o   duty value in force for the current period
// ---------------------------------------------------------------------------
module pwm_drive #(
    parameter int SLOT_CLKS = 20,
    parameter int STEPS     = 10,
    parameter bit INVERT    = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [3:0] duty_cycle_i,
    output logic       pwm_o,
    output logic       period_done_o,
    output logic [3:0] active_duty_o
);

    // A single-clock slot still needs a one-bit counter, so that the
    // register and its compare constant stay well formed.
    localparam int                SLOT_W    = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CLKS - 1);
    localparam logic [3:0]        STEP_LAST = 4'(STEPS - 1);
    localparam logic [3:0]        STEPS_L   = 4'(STEPS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q,  slot_d;
    logic [3:0]          step_q,  step_d;
    logic [3:0]          duty_q,  duty_d;
    logic                pwm_q,   pwm_d;
    logic                done_q,  done_d;

    logic [3:0]          duty_sat;
    logic                slot_wrap;
    logic                period_wrap;

    // Clamp requests above full scale, so that the compare below never sees
    // a duty that is larger than the number of slots.
    always_comb begin
        duty_sat = (duty_cycle_i > STEPS_L) ? STEPS_L : duty_cycle_i;
    end

    // Wrap detection on the current cycle's counter values. period_wrap is
    // true during period cycle P-1. The edge that ends this cycle is the only
    // point where a new duty is accepted while the block runs.
    always_comb begin
        slot_wrap   = (slot_q == SLOT_LAST);
        period_wrap = slot_wrap && (step_q == STEP_LAST);
    end

    // Next-state logic. Every register defaults to its idle value. Leaving
    // RUN therefore needs no extra code: the partial pulse is simply
    // dropped. The pwm and period_done outputs are computed from the
    // *next* counter and duty values. The registered outputs then line up
    // with the counters of the cycle they describe, and this holds at a
    // period boundary too, so a full-scale duty shows no gap.
    always_comb begin
        state_d = state_q;
        slot_d  = '0;
        step_d  = '0;
        duty_d  = '0;
        pwm_d   = INVERT;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = RUN;
                    duty_d  = duty_sat;
                end
            end
            RUN: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else begin
                    slot_d = slot_wrap ? '0 : slot_q + SLOT_W'(1);
                    if (slot_wrap) begin
                        step_d = (step_q == STEP_LAST) ? 4'd0 : step_q + 4'd1;
                    end else begin
                        step_d = step_q;
                    end
                    duty_d = period_wrap ? duty_sat : duty_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == RUN) begin
            pwm_d  = (step_d < duty_d) ^ INVERT;
            done_d = (slot_d == SLOT_LAST) && (step_d == STEP_LAST);
        end
    end

    // State and datapath registers. The reset forces the idle values at
    // once, also in the middle of a pulse, without waiting for a clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            slot_q  <= '0;
            step_q  <= '0;
            duty_q  <= '0;
            pwm_q   <= INVERT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            step_q  <= step_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
            done_q  <= done_d;
        end
    end

    assign pwm_o         = pwm_q;
    assign period_done_o = done_q;
    assign active_duty_o = duty_q;

endmodule

// File: tb/tb_pwm_drive.sv
// ---------------------------------------------------------------------------
// tb_pwm_drive
//
// Directed bench for pwm_drive. The main instance uses SLOT_CLKS=4 and
// STEPS=10 (P=40). An INVERT=1 copy shares the same inputs and must always
// show the complement of the pwm level. A third copy uses SLOT_CLKS=1 and
// STEPS=3; it has its own enable and covers one-clock slots together with
// duty saturation.
// ---------------------------------------------------------------------------
module tb_pwm_drive;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       en_s;
    logic [3:0] duty;

    logic       pwm,     pd;
    logic [3:0] ad;
    logic       pwm_inv, pd_inv;
    logic [3:0] ad_inv;
    logic       pwm_s,   pd_s;
    logic [3:0] ad_s;

    int total = 0;
    int bad   = 0;

    pwm_drive #(.SLOT_CLKS(4), .STEPS(10), .INVERT(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .duty_cycle_i(duty),
        .pwm_o(pwm), .period_done_o(pd), .active_duty_o(ad)
    );

    pwm_drive #(.SLOT_CLKS(4), .STEPS(10), .INVERT(1'b1)) dut_inv (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .duty_cycle_i(duty),
        .pwm_o(pwm_inv), .period_done_o(pd_inv), .active_duty_o(ad_inv)
    );

    pwm_drive #(.SLOT_CLKS(1), .STEPS(3), .INVERT(1'b0)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_s), .duty_cycle_i(duty),
        .pwm_o(pwm_s), .period_done_o(pd_s), .active_duty_o(ad_s)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and sample just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic enV, input logic [3:0] dutyV);
        en   = enV;
        duty = dutyV;
    endtask

    // Compares the main instance and the inverted copy against one
    // expectation. The inverted copy must show the complemented pwm level.
    task automatic checkOutput(input string tag, input logic pwmExp,
                               input logic pdExp, input logic [3:0] adExp);
        total++;
        assert (pwm === pwmExp) else begin
            bad++;
            $error("[TB] FAIL %s pwm observed=%b expected=%b", tag, pwm, pwmExp);
        end
        total++;
        assert (pd === pdExp) else begin
            bad++;
            $error("[TB] FAIL %s period_done observed=%b expected=%b", tag, pd, pdExp);
        end
        total++;
        assert (ad === adExp) else begin
            bad++;
            $error("[TB] FAIL %s active_duty observed=%0d expected=%0d", tag, ad, adExp);
        end
        total++;
        assert (pwm_inv === ~pwmExp) else begin
            bad++;
            $error("[TB] FAIL %s pwm_inv observed=%b expected=%b", tag, pwm_inv, ~pwmExp);
        end
        total++;
        assert (pd_inv === pdExp) else begin
            bad++;
            $error("[TB] FAIL %s period_done_inv observed=%b expected=%b", tag, pd_inv, pdExp);
        end
        total++;
        assert (ad_inv === adExp) else begin
            bad++;
            $error("[TB] FAIL %s active_duty_inv observed=%0d expected=%0d", tag, ad_inv, adExp);
        end
    endtask

    task automatic checkSmall(input string tag, input logic pwmExp,
                              input logic pdExp, input logic [3:0] adExp);
        total++;
        assert (pwm_s === pwmExp && pd_s === pdExp && ad_s === adExp) else begin
            bad++;
            $error("[TB] FAIL %s small pwm/pd/ad observed=%b/%b/%0d expected=%b/%b/%0d",
                   tag, pwm_s, pd_s, ad_s, pwmExp, pdExp, adExp);
        end
    endtask

    // Walks one full 40-clock period. The call starts in period cycle 0.
    // pwm must be high for the first adExp*4 clocks, and period_done must be
    // high only in cycle 39. At changeAt the duty input is replaced, and that
    // value applies only to the following period.
    task automatic runPeriod(input string name, input logic [3:0] adExp,
                             input logic [3:0] newDuty, input int changeAt);
        for (int c = 0; c < 40; c++) begin
            checkOutput($sformatf("%s c%0d", name, c),
                        logic'(c < int'(adExp) * 4), logic'(c == 39), adExp);
            if (c == changeAt) applyStimulus(1'b1, newDuty);
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en_s  = 1'b0;
        applyStimulus(1'b0, 4'd3);

        // Reset state.
        step();
        step();
        checkOutput("reset", 1'b0, 1'b0, 4'd0);
        checkSmall("reset_small", 1'b0, 1'b0, 4'd0);

        // Basic duty 3: 12 high, 28 low, repeating.
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'd3);
        step();
        runPeriod("basic1", 4'd3, 4'd3, -1);
        runPeriod("basic2", 4'd3, 4'd0, 10);

        // Full scale and saturation.
        runPeriod("duty0", 4'd0, 4'd10, 10);
        runPeriod("duty10", 4'd10, 4'd15, 10);
        runPeriod("duty15", 4'd10, 4'd2, 10);

        // Mid-period change 2 -> 7 at cycle 5.
        runPeriod("mid_old", 4'd2, 4'd7, 5);
        runPeriod("mid_new", 4'd7, 4'd5, 0);

        // Enable drop at period cycle 6 with duty 5.
        for (int c = 0; c < 7; c++) begin
            checkOutput($sformatf("drop c%0d", c), logic'(c < 20), 1'b0, 4'd5);
            if (c == 6) applyStimulus(1'b0, 4'd5);
            step();
        end
        checkOutput("drop_idle1", 1'b0, 1'b0, 4'd0);
        step();
        checkOutput("drop_idle2", 1'b0, 1'b0, 4'd0);

        // Re-raise with duty 4: 16 high clocks, period_done 40 clocks later.
        applyStimulus(1'b1, 4'd4);
        step();
        runPeriod("restart", 4'd4, 4'd4, -1);

        // The enable falls on the same edge as a period wrap: idle wins.
        for (int c = 0; c < 40; c++) begin
            checkOutput($sformatf("simul c%0d", c), logic'(c < 16), logic'(c == 39), 4'd4);
            if (c == 39) applyStimulus(1'b0, 4'd9);
            step();
        end
        checkOutput("simul_idle", 1'b0, 1'b0, 4'd0);

        // Asynchronous reset in the middle of a pulse.
        applyStimulus(1'b1, 4'd5);
        step();
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("pre_rst c%0d", c), 1'b1, 1'b0, 4'd5);
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst", 1'b0, 1'b0, 4'd0);
        #3;
        rst_n = 1'b1;
        step();
        runPeriod("post_rst", 4'd5, 4'd5, -1);

        // One-clock slots, three steps: duty 2, then 15 saturating to 3.
        applyStimulus(1'b0, 4'd2);
        en_s = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            checkSmall($sformatf("small_d2 c%0d", c), logic'(c < 2), logic'(c == 2), 4'd2);
            if (c == 0) duty = 4'd15;
            step();
        end
        for (int c = 0; c < 3; c++) begin
            checkSmall($sformatf("small_d15 c%0d", c), 1'b1, logic'(c == 2), 4'd3);
            step();
        end
        en_s = 1'b0;
        step();
        checkSmall("small_idle", 1'b0, 1'b0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_drive.md
# pwm_drive

Consumer end of the duty-cycle interface: takes the 4-bit `duty_cycle` step value produced by the animation ramp generator and converts it into a glitch-free PWM waveform for the LED pad. Each PWM period is divided into `STEPS` slots of `SLOT_CLKS` clocks. `duty_cycle` is sampled only at period boundaries, so a mid-period change never shortens or splits a pulse. A one-cycle `period_done` strobe marks the end of each period, so upstream pacing can lock to whole periods.

## Interface
- `SLOT_CLKS`, default 20: clocks per slot. Legal range ≥1.
- `STEPS`, default 10: slots per period; also the full-scale duty value. Legal range 1..15.
- `INVERT`, default 0: 1 = active-low pad. Inverts `pwm`, including its idle level.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `en` in 1: run enable, level-sensitive.
- `duty_cycle` in 4: requested on-slots per period. Values above `STEPS` saturate to `STEPS`.
- `pwm` out 1: registered PWM output.
- `period_done` out 1: registered one-cycle pulse in the last clock of each period.
- `active_duty` out 4: duty value in force for the current period.

## Operation
- **FSM states**
  - IDLE → RUN on an edge that samples `en`=1.
  - RUN → IDLE on an edge that samples `en`=0.
  - No other states.
- **Counters**
  - `slot` counts 0..`SLOT_CLKS`-1. Width is `$clog2(SLOT_CLKS)`, minimum 1 bit.
  - `step` counts 0..`STEPS`-1 and is 4 bits wide.
  - `slot` wraps to 0 and increments `step`. `step` wraps 0 after `STEPS`-1.
  - Period length P = `SLOT_CLKS`×`STEPS` clocks.
- **Duty latch**
  - `active_duty` is loaded with min(`duty_cycle`, `STEPS`) on the IDLE→RUN edge.
  - It is also loaded on the edge ending period cycle P-1.
  - It is held at all other times.
- **Output**
  - In RUN, `pwm` = (`step` < `active_duty`) XOR `INVERT`, evaluated on the cycle's own counter values. Implement this by registering the next-state compare.
  - In IDLE, `pwm` = `INVERT`, `active_duty` = 0, counters = 0 and `period_done` = 0.
- **period_done**
  - Asserted in RUN when `slot`=`SLOT_CLKS`-1 and `step`=`STEPS`-1.
- **Saturating compare**
  - `active_duty`=0 gives a constant off level.
  - `active_duty`=`STEPS` gives a constant on level, with no gap at period boundaries.

## Timing
- **Reset** (`rst_n` low, asynchronous, effective immediately, including mid-period):
  - `pwm`=`INVERT`, `period_done`=0, `active_duty`=0.
  - State IDLE, `slot`=0, `step`=0.
- **Start latency**
  - The edge sampling `en`=1 in IDLE makes the next cycle period cycle 0.
  - `pwm` is on in cycles 0..`active_duty`×`SLOT_CLKS`-1 and off for the remainder of the period.
- **Stop**
  - The edge sampling `en`=0 returns all outputs to idle values in the following cycle, whatever the period phase.
  - Any partial pulse is truncated; this is the only truncation case.
- **Duty update**
  - `duty_cycle` is sampled only on the edge that ends cycle P-1, while `period_done`=1.
  - The new value governs `pwm` from period cycle 0 of the next period.
  - Values presented at any other time are ignored.
- **Back-to-back periods**
  - Cycle 0 of the next period immediately follows cycle P-1; there are no idle cycles between periods.
- **`SLOT_CLKS`=1**
  - Each step lasts one clock.
  - `period_done` is high in cycle `STEPS`-1.
- **`STEPS`=1**
  - The only legal duties are 0 and 1.
  - `period_done` fires every `SLOT_CLKS` clocks.
- **Simultaneous events**
  - `en` falling on the same edge as a period wrap: IDLE wins. `active_duty` goes to 0 and no new duty is latched.

## Test plan
- **Basic duty:** `SLOT_CLKS`=4, `STEPS`=10, `duty_cycle`=3, `en`=1.
  - `pwm` high 12 clocks, then low 28 clocks, repeating.
  - `period_done` high exactly every 40th clock, aligned with the last low clock.
- **Full-scale and saturation:** `duty_cycle`=0, then 10, then 15 at successive boundaries.
  - Duty 0: one period fully low.
  - Duty 10: one period fully high, seamless into the next.
  - Duty 15: `active_duty`=10, `pwm` stays high.
- **Mid-period change:** `duty_cycle` changes 2→7 at period cycle 5.
  - The current period still has 8 high clocks (at `SLOT_CLKS`=4).
  - The next period has 28 high clocks.
  - `active_duty` changes on the edge after `period_done`.
- **Enable drop:** `en` drops at period cycle 6 with duty 5.
  - Next cycle: `pwm`=0, `active_duty`=0.
  - Re-raise `en` with duty 4: `pwm` high from new cycle 0 for 16 clocks, then `period_done` 40 clocks after restart.
- **Async reset:** pulse `rst_n` low between clock edges mid-pulse.
  - `pwm` goes low without waiting for a clock edge.
  - After release, and one edge sampling `en`=1, a clean period starts at cycle 0.
- **Inverted polarity:** `INVERT`=1, duty 3.
  - Waveform is the complement of the basic-duty case.
  - Idle and reset level is 1.
